// File: rtl/frame_swap_pkg.sv
// Shared constants for the frame swap controller: FSM encodings,
// register map, CTRL bit positions and the STATUS payload layout.
package frame_swap_pkg;

    localparam int unsigned AVL_ADDR_W = 2;
    localparam int unsigned AVL_DATA_W = 32;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_COMMIT  = 2'd2;

    localparam logic [AVL_ADDR_W-1:0] REG_CTRL   = 2'd0;
    localparam logic [AVL_ADDR_W-1:0] REG_STATUS = 2'd1;
    localparam logic [AVL_ADDR_W-1:0] REG_BASE1  = 2'd2;
    localparam logic [AVL_ADDR_W-1:0] REG_IRQ    = 2'd3;

    localparam int unsigned CTRL_SWAP_BIT    = 0;
    localparam int unsigned CTRL_AUTO_EN_BIT = 1;
    localparam int unsigned CTRL_PERIOD_LSB  = 4;
    localparam int unsigned CTRL_PERIOD_W    = 4;

    typedef struct packed {
        logic [15:0] frame_count;
        logic [13:0] rsvd;
        logic        pending;
        logic        front_sel;
    } status_t;

endpackage

// File: rtl/frame_swap_ctrl_if.sv
// Avalon register-block bus between the slave decode and the swap controller.
interface frame_swap_ctrl_if;
    import frame_swap_pkg::*;

    logic                  AVL_CS;
    logic                  AVL_READ;
    logic                  AVL_WRITE;
    logic [AVL_ADDR_W-1:0] AVL_ADDR;
    logic [AVL_DATA_W-1:0] AVL_WRITEDATA;
    logic [AVL_DATA_W-1:0] AVL_READDATA;

    modport master (
        output AVL_CS, AVL_READ, AVL_WRITE, AVL_ADDR, AVL_WRITEDATA,
        input  AVL_READDATA
    );

    modport slave (
        input  AVL_CS, AVL_READ, AVL_WRITE, AVL_ADDR, AVL_WRITEDATA,
        output AVL_READDATA
    );

endinterface

// File: rtl/frame_swap_regs.sv
// Register block of the frame swap controller: Avalon decode, CTRL/BASE1
// storage, the registered read mux and the sticky swap interrupt.
// Optional feature macro: FRAME_SWAP_IRQ_EN (sticky irq, reg 3 live).
module frame_swap_regs
    import frame_swap_pkg::*;
#(
    parameter int unsigned       ADDR_W        = 17,
    parameter logic [ADDR_W-1:0] BUF1_BASE_DEF = ADDR_W'('h2580),
    parameter int unsigned       FCNT_W        = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    frame_swap_ctrl_if.slave         bus,
    input  logic                     front_sel,
    input  logic                     pending,
    input  logic                     idle,
    input  logic                     commit,
    input  logic [FCNT_W-1:0]        frame_count,
    output logic                     swap_req_c,
    output logic                     auto_en,
    output logic [CTRL_PERIOD_W-1:0] auto_period,
    output logic [ADDR_W-1:0]        base1,
    output logic                     irq
);

    logic                  wr_c;
    logic                  rd_c;
    logic [AVL_DATA_W-1:0] rdata_c;
    status_t               status_c;
    logic                  unused_wdata;

    assign wr_c       = bus.AVL_CS && bus.AVL_WRITE;
    assign rd_c       = bus.AVL_CS && bus.AVL_READ;
    assign swap_req_c = wr_c && (bus.AVL_ADDR == REG_CTRL) && bus.AVL_WRITEDATA[CTRL_SWAP_BIT];
    assign unused_wdata = ^bus.AVL_WRITEDATA[AVL_DATA_W-1:ADDR_W];

    // CTRL and BASE1 storage; BASE1 only moves while no swap is in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            auto_en     <= 1'b0;
            auto_period <= '0;
            base1       <= BUF1_BASE_DEF;
        end else if (wr_c) begin
            if (bus.AVL_ADDR == REG_CTRL) begin
                auto_en     <= bus.AVL_WRITEDATA[CTRL_AUTO_EN_BIT];
                auto_period <= bus.AVL_WRITEDATA[CTRL_PERIOD_LSB +: CTRL_PERIOD_W];
            end
            if ((bus.AVL_ADDR == REG_BASE1) && idle) begin
                base1 <= bus.AVL_WRITEDATA[ADDR_W-1:0];
            end
        end
    end

`ifdef FRAME_SWAP_IRQ_EN
    // Sticky swap interrupt; a coincident commit beats the software clear
    always_ff @(posedge clk) begin
        if (rst) begin
            irq <= 1'b0;
        end else if (commit) begin
            irq <= 1'b1;
        end else if (wr_c && (bus.AVL_ADDR == REG_IRQ)) begin
            irq <= 1'b0;
        end
    end
`else
    logic unused_commit;
    assign unused_commit = commit;
    assign irq = 1'b0;
`endif

    // Read mux; swap_req is self-clearing so CTRL bit0 always reads 0
    always_comb begin
        status_c             = '0;
        status_c.frame_count = 16'(frame_count);
        status_c.pending     = pending;
        status_c.front_sel   = front_sel;
        rdata_c              = '0;
        case (bus.AVL_ADDR)
            REG_CTRL:   rdata_c = {24'h0, auto_period, 2'b00, auto_en, 1'b0};
            REG_STATUS: rdata_c = status_c;
            REG_BASE1:  rdata_c = AVL_DATA_W'(base1);
            REG_IRQ:    rdata_c = {31'h0, irq};
            default:    rdata_c = '0;
        endcase
    end

    // Read data register holds between reads
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.AVL_READDATA <= '0;
        end else if (rd_c) begin
            bus.AVL_READDATA <= rdata_c;
        end
    end

endmodule

// File: rtl/frame_swap_ctrl.sv
// Double-buffer sequencer: tracks front/back buffers and swaps them only
// at frame boundaries, on software request or auto-swap period.
// Optional feature macro: FRAME_SWAP_IRQ_EN (handled in frame_swap_regs).
module frame_swap_ctrl
    import frame_swap_pkg::*;
#(
    parameter int unsigned       ADDR_W        = 17,
    parameter logic [ADDR_W-1:0] BUF1_BASE_DEF = ADDR_W'('h2580),
    parameter int unsigned       FCNT_W        = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              frame_end,
    input  logic              wr_busy,
    frame_swap_ctrl_if.slave  avl,
    output logic              front_sel,
    output logic [ADDR_W-1:0] front_base,
    output logic [ADDR_W-1:0] back_base,
    output logic              swap_done,
    output logic              irq
);

    localparam int unsigned ACNT_W = CTRL_PERIOD_W;

    logic [1:0]         state;
    logic [1:0]         state_next;
    logic               swap_req_c;
    logic               auto_en;
    logic [ACNT_W-1:0]  auto_period;
    logic [ACNT_W-1:0]  auto_limit_c;
    logic [ACNT_W-1:0]  auto_cnt;
    logic               auto_hit_c;
    logic [ADDR_W-1:0]  base1;
    logic [FCNT_W-1:0]  frame_count;

    frame_swap_regs #(
        .ADDR_W        (ADDR_W),
        .BUF1_BASE_DEF (BUF1_BASE_DEF),
        .FCNT_W        (FCNT_W)
    ) u_regs (
        .clk         (CLK),
        .rst         (RESET),
        .bus         (avl),
        .front_sel   (front_sel),
        .pending     (state == ST_PENDING),
        .idle        (state == ST_IDLE),
        .commit      (state == ST_COMMIT),
        .frame_count (frame_count),
        .swap_req_c  (swap_req_c),
        .auto_en     (auto_en),
        .auto_period (auto_period),
        .base1       (base1),
        .irq         (irq)
    );

    // A period of 0 behaves as 1 (swap every frame)
    assign auto_limit_c = (auto_period == '0) ? ACNT_W'(1) : auto_period;
    assign auto_hit_c   = frame_end && auto_en && ((auto_cnt + ACNT_W'(1)) == auto_limit_c);

    // Buffer 0 sits at word 0, buffer 1 at the programmable base
    assign front_base = front_sel ? base1 : '0;
    assign back_base  = front_sel ? '0 : base1;

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: requests only latch in IDLE, commits wait for an idle writer
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (swap_req_c || auto_hit_c) state_next = ST_PENDING;
            ST_PENDING: if (frame_end && !wr_busy)    state_next = ST_COMMIT;
            ST_COMMIT:  state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Front buffer flips at the end of COMMIT; swap_done marks the COMMIT cycle
    always_ff @(posedge CLK) begin
        if (RESET) begin
            front_sel <= 1'b0;
            swap_done <= 1'b0;
        end else begin
            front_sel <= front_sel ^ (state == ST_COMMIT);
            swap_done <= (state_next == ST_COMMIT);
        end
    end

    // Frame counter and auto-swap period counter
    always_ff @(posedge CLK) begin
        if (RESET) begin
            frame_count <= '0;
            auto_cnt    <= '0;
        end else begin
            if (frame_end) begin
                frame_count <= frame_count + FCNT_W'(1);
            end
            if (!auto_en) begin
                auto_cnt <= '0;
            end else if (frame_end) begin
                auto_cnt <= auto_hit_c ? '0 : auto_cnt + ACNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_frame_swap_ctrl.sv
// Self-checking bench for frame_swap_ctrl: directed scenarios followed by
// random traffic, all compared against a behavioural model of the swap rules.
module tb_frame_swap_ctrl;

    localparam int unsigned       ADDR_W   = 17;
    localparam logic [ADDR_W-1:0] BUF1_DEF = 17'h2580;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              frame_end;
    logic              wr_busy;
    logic              front_sel;
    logic [ADDR_W-1:0] front_base;
    logic [ADDR_W-1:0] back_base;
    logic              swap_done;
    logic              irq;

    frame_swap_ctrl_if avl ();

    frame_swap_ctrl #(
        .ADDR_W        (ADDR_W),
        .BUF1_BASE_DEF (BUF1_DEF),
        .FCNT_W        (16)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .frame_end  (frame_end),
        .wr_busy    (wr_busy),
        .avl        (avl),
        .front_sel  (front_sel),
        .front_base (front_base),
        .back_base  (back_base),
        .swap_done  (swap_done),
        .irq        (irq)
    );

    always #5 CLK = ~CLK;

    int n_assert = 0;
    int n_fail   = 0;
    int commits_seen = 0;

    // Behavioural model: a swap request becomes "pending", a pending swap
    // is carried out in the cycle after a frame_end with the writer idle.
    bit              m_front, m_pending, m_swapping, m_auto_en, m_irq;
    int unsigned     m_period, m_acnt, m_fcnt;
    logic [16:0]     m_base1;
    logic [31:0]     m_rdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input bit fe, input bit busy, input bit cs, input bit rd,
                              input bit wr, input logic [1:0] addr, input logic [31:0] wd,
                              input bit rst);
        bit          idle, hit, start_swap, wr_en;
        int unsigned limit;
        logic [31:0] rv;
        if (rst) begin
            m_front = 0; m_pending = 0; m_swapping = 0; m_auto_en = 0; m_irq = 0;
            m_period = 0; m_acnt = 0; m_fcnt = 0; m_base1 = BUF1_DEF; m_rdata = 0;
            return;
        end
        idle  = !m_pending && !m_swapping;
        wr_en = cs && wr;
        case (addr)
            2'd0:    rv = {24'h0, 4'(m_period), 2'b00, m_auto_en, 1'b0};
            2'd1:    rv = {16'(m_fcnt), 14'h0, m_pending, m_front};
            2'd2:    rv = 32'(m_base1);
            default: rv = {31'h0, m_irq};
        endcase
        if (cs && rd) m_rdata = rv;
        limit = (m_period == 0) ? 1 : m_period;
        hit   = fe && m_auto_en && (((m_acnt + 1) % 16) == limit);
        start_swap = m_pending && fe && !busy;
`ifdef FRAME_SWAP_IRQ_EN
        if (m_swapping) m_irq = 1;
        else if (wr_en && addr == 2'd3) m_irq = 0;
`endif
        if (m_swapping) m_front = !m_front;
        m_pending = (m_pending && !start_swap) ||
                    (idle && ((wr_en && addr == 2'd0 && wd[0]) || hit));
        if (!m_auto_en) m_acnt = 0;
        else if (fe) m_acnt = hit ? 0 : (m_acnt + 1) % 16;
        if (fe) m_fcnt = (m_fcnt + 1) % 65536;
        if (wr_en && addr == 2'd0) begin
            m_auto_en = wd[1];
            m_period  = 32'(wd[7:4]);
        end
        if (wr_en && addr == 2'd2 && idle) m_base1 = wd[16:0];
        m_swapping = start_swap;
    endtask

    task automatic check_outputs();
        chk("front_sel",  32'(front_sel),  32'(m_front));
        chk("swap_done",  32'(swap_done),  32'(m_swapping));
        chk("front_base", 32'(front_base), m_front ? 32'(m_base1) : 32'h0);
        chk("back_base",  32'(back_base),  m_front ? 32'h0 : 32'(m_base1));
        chk("irq",        32'(irq),        32'(m_irq));
        chk("readdata",   avl.AVL_READDATA, m_rdata);
        if (swap_done === 1'b1) commits_seen++;
    endtask

    // One clock: apply inputs, let the edge pass, update model, compare
    task automatic cycle(input bit fe, input bit busy, input bit cs, input bit rd,
                         input bit wr, input logic [1:0] addr, input logic [31:0] wd,
                         input bit rst);
        frame_end         = fe;
        wr_busy           = busy;
        RESET             = rst;
        avl.AVL_CS        = cs;
        avl.AVL_READ      = rd;
        avl.AVL_WRITE     = wr;
        avl.AVL_ADDR      = addr;
        avl.AVL_WRITEDATA = wd;
        @(posedge CLK);
        model_edge(fe, busy, cs, rd, wr, addr, wd, rst);
        #1;
        frame_end = 0; RESET = 0; avl.AVL_CS = 0; avl.AVL_READ = 0; avl.AVL_WRITE = 0;
        check_outputs();
    endtask

    task automatic idle_cycles(input int n, input bit busy);
        for (int i = 0; i < n; i++) cycle(0, busy, 0, 0, 0, 2'd0, 32'h0, 0);
    endtask
    task automatic do_reset();
        cycle(0, 0, 0, 0, 0, 2'd0, 32'h0, 1);
        cycle(0, 0, 0, 0, 0, 2'd0, 32'h0, 1);
    endtask
    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        cycle(0, 0, 1, 0, 1, a, d, 0);
    endtask
    task automatic rd_reg(input logic [1:0] a);
        cycle(0, 0, 1, 1, 0, a, 32'h0, 0);
    endtask
    task automatic frame(input bit busy);
        cycle(1, busy, 0, 0, 0, 2'd0, 32'h0, 0);
    endtask

    initial begin
        int base_commits;
        frame_end = 0; wr_busy = 0; RESET = 1;
        avl.AVL_CS = 0; avl.AVL_READ = 0; avl.AVL_WRITE = 0;
        avl.AVL_ADDR = 0; avl.AVL_WRITEDATA = 0;

        // Reset state
        do_reset();
        rd_reg(2'd1);
        chk("reset_status", avl.AVL_READDATA, 32'h0);
        chk("reset_front_base", 32'(front_base), 32'h0);
        chk("reset_back_base", 32'(back_base), 32'h2580);

        // Software swap
        wr_reg(2'd0, 32'h1);
        idle_cycles(4, 0);
        frame(0);
        chk("sw_swap_done", 32'(swap_done), 32'h1);
        idle_cycles(1, 0);
        chk("sw_front_sel", 32'(front_sel), 32'h1);
        chk("sw_front_base", 32'(front_base), 32'h2580);
        chk("sw_back_base", 32'(back_base), 32'h0);
        rd_reg(2'd1);
        chk("sw_status", avl.AVL_READDATA, 32'h0001_0001);

        // Commit blocked by a busy writer, retried next frame
        wr_reg(2'd0, 32'h1);
        frame(1);
        idle_cycles(2, 1);
        rd_reg(2'd1);
        chk("busy_status", avl.AVL_READDATA, 32'h0002_0003);
        frame(0);
        idle_cycles(2, 0);
        chk("busy_front_sel", 32'(front_sel), 32'h0);

        // Auto mode, period 3, nine frames
        do_reset();
        wr_reg(2'd0, 32'h32);
        base_commits = commits_seen;
        for (int f = 0; f < 9; f++) begin
            frame(0);
            idle_cycles(3, 0);
        end
        chk("auto_commits", 32'(commits_seen - base_commits), 32'd2);
        rd_reg(2'd1);
        chk("auto_status", avl.AVL_READDATA, 32'h0009_0002);
        wr_reg(2'd0, 32'h0);
        frame(0);
        idle_cycles(2, 0);

        // Repeated requests while pending and a blocked BASE1 write
        wr_reg(2'd0, 32'h1);
        wr_reg(2'd0, 32'h1);
        wr_reg(2'd0, 32'h1);
        wr_reg(2'd2, 32'h1234);
        base_commits = commits_seen;
        frame(0);
        idle_cycles(3, 0);
        chk("multi_req_commits", 32'(commits_seen - base_commits), 32'd1);
        rd_reg(2'd2);
        chk("base1_locked", avl.AVL_READDATA, 32'h2580);
        wr_reg(2'd2, 32'h1234);
        rd_reg(2'd2);
        chk("base1_written", avl.AVL_READDATA, 32'h1234);

        // Interrupt: clear coinciding with the next commit keeps irq set
        wr_reg(2'd0, 32'h1);
        frame(0);
        cycle(0, 0, 1, 0, 1, 2'd3, 32'h0, 0);
        idle_cycles(1, 0);
        rd_reg(2'd3);
        wr_reg(2'd3, 32'h0);
        idle_cycles(1, 0);

        // Request in the same cycle as frame_end waits for the next frame
        cycle(1, 0, 1, 0, 1, 2'd0, 32'h1, 0);
        idle_cycles(2, 0);
        frame(0);
        idle_cycles(2, 0);

        // Reset while pending and while committing
        wr_reg(2'd0, 32'h1);
        do_reset();
        wr_reg(2'd0, 32'h1);
        frame(0);
        do_reset();
        chk("reset_mid_commit", {31'h0, front_sel}, 32'h0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit          fe, busy, cs, rd, wr, rst;
            logic [1:0]  a;
            logic [31:0] d;
            fe   = ($urandom_range(0, 5) == 0);
            busy = ($urandom_range(0, 2) == 0);
            cs   = ($urandom_range(0, 3) == 0);
            rd   = 1'($urandom);
            wr   = 1'($urandom);
            a    = 2'($urandom);
            d    = $urandom;
            rst  = ($urandom_range(0, 399) == 0);
            cycle(fe, busy, cs, rd, wr, a, d, rst);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_swap_ctrl.md
Name: frame_swap_ctrl

Overview:
Sequences the double-buffered frame memory. Tracks which buffer the VGA fetch path displays (front) and which buffer Avalon writes target (back), and schedules front/back swaps only at frame boundaries. A swap is triggered either by a software request or by an auto-swap period counter. Sits between the Avalon slave decode and the frame memory interface; supplies both base addresses and the buffer select.

Parameters:
ADDR_W, 17, width of word addresses and base registers
BUF1_BASE_DEF, 17'h2580, reset value of the buffer-1 base word address (buffer 0 base fixed at 0)
FCNT_W, 16, width of the frame counter

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
frame_end  in  1  one-cycle pulse in CLK domain when the last pixel of a frame has been fetched
wr_busy  in  1  high while a back-buffer write burst is in flight; blocks commit
AVL_CS  in  1  register-block chip select
AVL_READ  in  1  register read strobe
AVL_WRITE  in  1  register write strobe
AVL_ADDR  in  2  register index
AVL_WRITEDATA  in  32  register write data
AVL_READDATA  out  32  register read data, registered
front_sel  out  1  buffer currently displayed (0/1); back buffer = !front_sel
front_base  out  ADDR_W  base word address of front buffer
back_base  out  ADDR_W  base word address of back buffer
swap_done  out  1  one-cycle pulse on the cycle front_sel changes
irq  out  1  sticky swap interrupt (optional feature)

Behaviour:
- Reset values: front_sel=0, front_base=0, back_base=BUF1_BASE_DEF, AVL_READDATA=0, swap_done=0, irq=0, state IDLE, frame_count=0, auto_en=0, auto_period=0, auto_cnt=0, base1=BUF1_BASE_DEF.
- Registers (word index): 0 CTRL: W bit0 swap_req (self-clearing, write-1), RW bit1 auto_en, RW bits[7:4] auto_period. 1 STATUS (RO): bit0 front_sel, bit1 pending, bits[31:16] frame_count. 2 BASE1 (RW): bits[ADDR_W-1:0] base1; writes ignored while state != IDLE. 3 IRQ: read bit0 = irq; write any value clears irq.
- Reads: AVL_READDATA updated one cycle after AVL_CS&&AVL_READ; holds its value otherwise. Unused bits read 0.
- FSM IDLE -> PENDING: CTRL write with bit0=1, or auto trigger. PENDING -> COMMIT: frame_end && !wr_busy. PENDING stays PENDING if frame_end && wr_busy (retry next frame). COMMIT -> IDLE unconditionally after one cycle.
- In COMMIT: front_sel toggles at the cycle's end edge; swap_done=1 during COMMIT; front_base/back_base recomputed combinationally from front_sel and base1 (buffer0 base=0).
- swap_req written in PENDING or COMMIT is ignored (never double-toggles).
- swap_req written in the same cycle as frame_end while IDLE: enters PENDING; commit waits for the next frame_end.
- frame_count increments on every frame_end, wraps at 2^FCNT_W.
- Auto mode: auto_cnt increments on each frame_end while auto_en; when auto_cnt+1 == max(auto_period,1), auto_cnt<=0 and PENDING is raised the same cycle (commit at the following frame_end). Clearing auto_en resets auto_cnt to 0; an existing PENDING stays.
- RESET mid-PENDING or mid-COMMIT: all state returns to reset values; no swap_done pulse.

Optional Feature:
FRAME_SWAP_IRQ_EN: defined -> irq set on each COMMIT cycle (visible next cycle), cleared by write to reg 3; if set and clear coincide, set wins. Undefined -> irq tied 0, reg 3 reads 0, writes ignored.

Decomposition:
- Package frame_swap_pkg: state enum (IDLE, PENDING, COMMIT), register index constants (REG_CTRL=0, REG_STATUS=1, REG_BASE1=2, REG_IRQ=3), CTRL bit-position constants.
- One sub-module natural: frame_swap_regs (Avalon decode, CTRL/BASE1/IRQ storage, read mux); FSM and counters in top.

Test Plan:
- Reset, read STATUS -> 0x0000_0000; front_base=0, back_base=0x2580.
- Write CTRL=1, frame_end after 5 cycles, wr_busy=0 -> swap_done 1 cycle after frame_end, front_sel=1, front_base=0x2580, back_base=0, STATUS bit1 cleared.
- Write CTRL=1, frame_end with wr_busy=1 -> no swap, STATUS=0x2 pending; next frame_end with wr_busy=0 -> swap.
- CTRL=0x32 (auto_en, period 3), 9 frame_ends -> exactly 2 commits, at the 4th and 7th frame_end (trigger at 3rd/6th, 9th leaves PENDING); frame_count=9.
- Write CTRL=1 twice while PENDING, one frame_end -> exactly one toggle; BASE1 write during PENDING ignored.
- FRAME_SWAP_IRQ_EN: after swap irq=1; write reg 3 in the same cycle as the next COMMIT -> irq stays 1.
